// File: rtl/stepper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stepper_pkg
// Description : Shared definitions for the parallel-in/serial-out transmitter.
//               Holds the frame FSM state encodings so that every file
//               decoding the state uses the same values.
// Revision    : 1.0 - initial release
// ============================================================================
package stepper_pkg;

  localparam int unsigned c_STATE_W = 2;

  typedef logic [c_STATE_W-1:0] state_t;

  // Frame FSM encodings
  localparam logic [1:0] c_ST_IDLE  = 2'd0;  // waiting for a word
  localparam logic [1:0] c_ST_SHIFT = 2'd1;  // bits on the line
  localparam logic [1:0] c_ST_GUARD = 2'd2;  // one-cycle end-of-frame gap

endpackage : stepper_pkg
`default_nettype wire

// File: rtl/bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : bit_timer
// Description : Bit-period timer. While run is high it counts CLK_DIV clock
//               cycles per serial bit. phase is low for the first half of the
//               bit and high for the second half; bit_end marks the final
//               cycle of each bit. While run is low the counter is held at 0
//               so the first cycle of run is always the first cycle of a bit.
// Ports       : clk_in  - system clock
//               rst_in  - synchronous active-high reset
//               run     - count enable (high while a frame is shifting)
//               phase   - 0 in first half of bit, 1 in second half
//               bit_end - high in the last cycle of each bit
// Revision    : 1.0 - initial release
// ============================================================================
module bit_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic run,
  output logic phase,
  output logic bit_end
);

  localparam int                 c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_HALF  = c_DIV_W'(CLK_DIV / 2);
  localparam logic [c_DIV_W-1:0] c_LAST  = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_DIV_W-1:0] c_ONE   = c_DIV_W'(1);

  logic [c_DIV_W-1:0] r_div;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_div <= '0;
    end else if (!run) begin
      r_div <= '0;
    end else if (r_div == c_LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + c_ONE;
    end
  end

  assign phase   = run && (r_div >= c_HALF);
  assign bit_end = run && (r_div == c_LAST);

endmodule : bit_timer
`default_nettype wire

// File: rtl/piso_tx.sv
`default_nettype none
// ============================================================================
// Module      : piso_tx
// Description : Parallel-in/serial-out transmitter. Accepts a SIZE-bit word
//               with a valid/ready handshake and shifts it out MSB first with
//               a generated bit clock (CLK_DIV system clocks per bit) and a
//               frame enable. A one-cycle GUARD state after the last bit
//               carries the done pulse.
// Ports       : clk_in    - system clock
//               rst_in    - synchronous active-high reset
//               data_in   - parallel word to transmit
//               valid_in  - data_in is valid
//               ready_out - block can accept a word
//               data_out  - serial data, MSB first
//               sclk_out  - serial bit clock (receiver samples on rise)
//               en_out    - high while bits are on the line
//               done_out  - one-cycle end-of-frame pulse
// Revision    : 1.0 - initial release
// ============================================================================
module piso_tx
  import stepper_pkg::*;
#(
  parameter int SIZE    = 8,
  parameter int CLK_DIV = 4
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [SIZE-1:0] data_in,
  input  logic            valid_in,
  output logic            ready_out,
  output logic            data_out,
  output logic            sclk_out,
  output logic            en_out,
  output logic            done_out
);

  localparam int               c_BIT_W    = $clog2(SIZE + 1);
  localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(SIZE - 1);
  localparam logic [c_BIT_W-1:0] c_BIT_ONE  = c_BIT_W'(1);

  state_t              r_state;
  logic [SIZE-1:0]     r_shift;
  logic [c_BIT_W-1:0]  r_bit;

  logic                w_run;
  logic                w_phase;
  logic                w_bit_end;

  assign w_run = (r_state == c_ST_SHIFT);

  bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_timer (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .run     (w_run),
    .phase   (w_phase),
    .bit_end (w_bit_end)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= c_ST_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          // ready_out is simply "in IDLE and not in reset", so valid_in alone
          // completes the handshake here.
          if (valid_in) begin
            r_shift <= data_in;
            r_bit   <= '0;
            r_state <= c_ST_SHIFT;
          end
        end
        c_ST_SHIFT: begin
          if (w_bit_end) begin
            // The next bit is presented at the MSB so data_out only moves at
            // the start of a bit, half a period ahead of the sclk rise.
            r_shift <= {r_shift[SIZE-2:0], 1'b0};
            if (r_bit == c_LAST_BIT) begin
              r_bit   <= '0;
              r_state <= c_ST_GUARD;
            end else begin
              r_bit   <= r_bit + c_BIT_ONE;
            end
          end
        end
        c_ST_GUARD: begin
          r_state <= c_ST_IDLE;
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  // All line outputs decode from registered state, so a reset edge clears
  // them in the very next cycle and a mid-frame abort never reaches GUARD.
  assign ready_out = (r_state == c_ST_IDLE) && !rst_in;
  assign en_out    = w_run;
  assign sclk_out  = w_run && w_phase;
  assign data_out  = w_run && r_shift[SIZE-1];
  assign done_out  = (r_state == c_ST_GUARD);

endmodule : piso_tx
`default_nettype wire

// File: tb/tb_piso_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_tx
// Description : Self-checking bench for piso_tx. A cycle-level reference of a
//               frame is computed arithmetically from the accepted word
//               (bit index and phase from the cycle number), and a loopback
//               shift receiver clocked by sclk_out rebuilds each word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_tx;

  localparam int SIZE    = 8;
  localparam int CLK_DIV = 4;
  localparam int N       = SIZE * CLK_DIV;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] data;
  logic       valid;
  wire        ready, dout, sclk, en, done;

  logic [1:0] data2;
  logic       valid2;
  wire        ready2, dout2, sclk2, en2, done2;

  piso_tx #(.SIZE(SIZE), .CLK_DIV(CLK_DIV)) dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .data_in   (data),
    .valid_in  (valid),
    .ready_out (ready),
    .data_out  (dout),
    .sclk_out  (sclk),
    .en_out    (en),
    .done_out  (done)
  );

  piso_tx #(.SIZE(2), .CLK_DIV(2)) dut2 (
    .clk_in    (clk),
    .rst_in    (rst),
    .data_in   (data2),
    .valid_in  (valid2),
    .ready_out (ready2),
    .data_out  (dout2),
    .sclk_out  (sclk2),
    .en_out    (en2),
    .done_out  (done2)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_done_cyc = -100;

  always @(posedge clk) cyc <= cyc + 1;

  // Loopback serial-to-parallel receiver
  logic [7:0] rx_word = 8'h00;
  always @(posedge sclk) if (en) rx_word <= {rx_word[6:0], dout};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_en"},   en,   0);
    chk({tag, "_sclk"}, sclk, 0);
    chk({tag, "_data"}, dout, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Called at a falling edge while the DUT is in IDLE; returns at the falling
  // edge of the IDLE cycle following the GUARD cycle.
  task automatic send_frame(input logic [7:0] w, input bit hold_valid,
                            input bit poke_data, input bit b2b);
    int en_cnt;
    int k;
    int ph;
    data  = w;
    valid = 1'b1;
    chk("ready_pre", ready, 1);
    chk_idle("idle_pre");
    @(negedge clk);
    valid = hold_valid;
    if (b2b) chk("b2b_gap", cyc - last_done_cyc, 2);
    en_cnt = 0;
    for (int t = 1; t <= N; t++) begin
      k  = (t - 1) / CLK_DIV;
      ph = (t - 1) % CLK_DIV;
      chk("en",    en,   1);
      chk("sclk",  sclk, (ph >= CLK_DIV / 2) ? 1 : 0);
      chk("data",  dout, w[SIZE-1-k]);
      chk("done",  done, 0);
      chk("ready", ready, 0);
      if (en) en_cnt++;
      if (poke_data && t == N / 2) data = 8'h00;
      @(negedge clk);
    end
    chk("en_len",     en_cnt, N);
    chk("guard_done", done, 1);
    chk("guard_en",   en,   0);
    chk("guard_sclk", sclk, 0);
    chk("guard_data", dout, 0);
    chk("guard_rdy",  ready, 0);
    last_done_cyc = cyc;
    @(negedge clk);
    chk("ready_post", ready, 1);
    chk("done_post",  done,  0);
  endtask

  initial begin
    logic [7:0] w;
    logic [3:0] e_sclk2;
    logic [3:0] e_data2;
    int         gap;
    rst    = 1'b1;
    valid  = 1'b0;
    data   = 8'h00;
    valid2 = 1'b0;
    data2  = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 0);
    chk_idle("rst");
    chk("rst_ready2", ready2, 0);
    rst = 1'b0;
    #1;
    chk("rst_rel_ready", ready, 1);
    @(negedge clk);

    // Reference word from the example frame
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);

    // Loopback receive
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    chk("loopback_3C", rx_word, 8'h3C);

    // Back-to-back with valid held high
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    chk("loopback_00", rx_word, 8'h00);

    // data_in changes mid-frame
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
    chk("loopback_C3", rx_word, 8'hC3);

    // Random words with random idle gaps
    for (int i = 0; i < 6; i++) begin
      w   = 8'($urandom);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        chk_idle("gap");
        chk("gap_ready", ready, 1);
        @(negedge clk);
      end
      send_frame(w, 1'b0, 1'b0, 1'b0);
      chk("loopback_rand", rx_word, w);
    end

    // Reset during bit 3 of 8'h81
    data  = 8'h81;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    for (int t = 1; t <= 3 * CLK_DIV + 1; t++) begin
      chk("ab_en",   en,   1);
      chk("ab_data", dout, w_bit81((t - 1) / CLK_DIV));
      if (t < 3 * CLK_DIV + 1) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("ab_en_off",   en,    0);
    chk("ab_sclk_off", sclk,  0);
    chk("ab_done",     done,  0);
    chk("ab_ready",    ready, 0);
    @(negedge clk);
    chk_idle("ab_hold");
    rst = 1'b0;
    #1;
    chk("ab_ready_rel", ready, 1);
    for (int t = 0; t < N + 4; t++) begin
      @(negedge clk);
      chk_idle("ab_after");
    end

    // Minimal configuration: SIZE=2, CLK_DIV=2, word 2'b10
    e_sclk2 = 4'b1010;  // index = cycle after acceptance - 1
    e_data2 = 4'b0011;
    chk("s2_ready", ready2, 1);
    data2  = 2'b10;
    valid2 = 1'b1;
    @(negedge clk);
    valid2 = 1'b0;
    for (int t = 0; t < 4; t++) begin
      chk("s2_en",   en2,   1);
      chk("s2_sclk", sclk2, e_sclk2[t]);
      chk("s2_data", dout2, e_data2[t]);
      chk("s2_done", done2, 0);
      @(negedge clk);
    end
    chk("s2_guard_done", done2, 1);
    chk("s2_guard_en",   en2,   0);
    @(negedge clk);
    chk("s2_ready_post", ready2, 1);
    chk("s2_done_post",  done2,  0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic w_bit81(input int k);
    logic [7:0] v;
    v = 8'h81;
    return v[7-k];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_piso_tx
`default_nettype wire

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 The block SHALL have parameter SIZE, default 8, giving the word width in bits; legal range SIZE >= 2.
REQ-002 The block SHALL have parameter CLK_DIV, default 4, giving clk_in cycles per serial bit; legal values are even and >= 2.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port clk_in, input, 1 bit: system clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_in, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port data_in, input, SIZE bits: parallel word to transmit.
REQ-007 The block SHALL have port valid_in, input, 1 bit: data_in is valid.
REQ-008 The block SHALL have port ready_out, output, 1 bit: block can accept a word.
REQ-009 The block SHALL have port data_out, output, 1 bit: serial data, MSB first.
REQ-010 The block SHALL have port sclk_out, output, 1 bit: serial bit clock; receiver samples on its rising edge.
REQ-011 The block SHALL have port en_out, output, 1 bit: frame enable; high while bits are on the line.
REQ-012 The block SHALL have port done_out, output, 1 bit: one-cycle end-of-frame pulse.

Function
REQ-013 The block SHALL implement FSM states IDLE, SHIFT and GUARD; reset state is IDLE.
REQ-014 ready_out SHALL equal (state == IDLE) && !rst_in, combinationally.
REQ-015 A word SHALL be accepted on a rising edge where valid_in && ready_out; data_in is then copied into a SIZE-bit shift register and the state moves to SHIFT.
REQ-016 In SHIFT, each bit SHALL last exactly CLK_DIV cycles: sclk_out is 0 for the first CLK_DIV/2 cycles and 1 for the second CLK_DIV/2 cycles.
REQ-017 data_out SHALL change only at bit start (sclk_out low phase), so it is stable for CLK_DIV/2 cycles before each sclk_out rising edge.
REQ-018 Latency: in the cycle after acceptance, en_out SHALL be 1, sclk_out 0, and data_out = accepted word bit [SIZE-1].
REQ-019 Bit k (k = 0..SIZE-1) SHALL carry accepted word bit [SIZE-1-k]; the shift register shifts left by one at each bit boundary.
REQ-020 en_out SHALL be high for exactly SIZE*CLK_DIV consecutive cycles per frame.
REQ-021 After the last bit, the FSM SHALL enter GUARD for exactly 1 cycle: en_out=0, sclk_out=0, data_out=0, done_out=1.
REQ-022 GUARD SHALL always transition to IDLE; the first new acceptance is possible at cycle SIZE*CLK_DIV+2 after the accepting edge.
REQ-023 valid_in and data_in SHALL be ignored outside IDLE; changes to data_in mid-frame SHALL NOT affect the frame.
REQ-024 With valid_in held high continuously, frames SHALL run back-to-back, separated only by GUARD plus the IDLE acceptance cycle.
REQ-025 The divider counter SHALL be $clog2(CLK_DIV) bits wide and the bit counter $clog2(SIZE+1) bits wide; both SHALL wrap to 0 at each bit and frame boundary respectively.
REQ-026 In IDLE, data_out, sclk_out, en_out and done_out SHALL all be 0.

Reset
REQ-027 While rst_in is high at a rising edge, the next state SHALL be IDLE, counters and shift register 0, and data_out, sclk_out, en_out and done_out 0.
REQ-028 Reset mid-frame SHALL abort the frame: no done_out pulse, and no further sclk_out edge after the reset edge.
REQ-029 ready_out SHALL be 0 during rst_in high and 1 in the first cycle after rst_in falls.

Structure
REQ-030 State encodings (IDLE, SHIFT, GUARD) SHALL live in the shared package stepper_pkg.
REQ-031 Bit-period timing (divider counter, half-period and end-of-bit ticks) SHALL be a sub-module bit_timer with parameter CLK_DIV, inputs clk_in, rst_in and run, and outputs phase and bit_end.

Verification
REQ-032 SIZE=8, CLK_DIV=4, accept 8'hA5 -> data_out sequence 1,0,1,0,0,1,0,1; en_out high 32 cycles; done_out high at cycle 33.
REQ-033 Loopback into the existing serial-to-parallel receiver (receiver clock = sclk_out, enable = en_out, data = data_out), send 8'h3C -> receiver output 8'h3C after done_out.
REQ-034 valid_in held high with words 8'hFF then 8'h00 -> two frames; second frame's first en_out cycle is exactly 2 cycles after the first done_out cycle.
REQ-035 Assert rst_in during bit 3 of frame 8'h81 -> next cycle en_out=0, sclk_out=0, no done_out; ready_out=1 in the cycle after rst_in falls.
REQ-036 Change data_in to 8'h00 mid-frame after accepting 8'hC3 -> serial output is still 8'hC3.
REQ-037 SIZE=2, CLK_DIV=2, accept 2'b10 -> en_out high 4 cycles, sclk_out pattern 0,1,0,1, data_out 1,1,0,0.
